// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the key loader, the inverse key schedule and the
// inverse-cipher round logic that consumes round keys.
interface aes_inv_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ack;
    logic         busy;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    modport master (
        output start, key_in, rk_ack,
        input  busy, rk_valid, rk_out, rk_round, done
    );

    modport slave (
        input  start, key_in, rk_ack,
        output busy, rk_valid, rk_out, rk_round, done
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0.
// Define AES_FWD_EXPAND_EN to accept the cipher key and forward-expand first.
module aes_inv_key_sched (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_key_sched_if.slave   bus
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX[{8'd255 - b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        sub_rot = {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        rcon = {c, 24'h0};
    endfunction

`ifdef AES_FWD_EXPAND_EN
    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

    state_t       state, state_nxt;
    logic [127:0] key_q, key_nxt;
    logic [3:0]   cnt_q, cnt_nxt;
    logic         done_q, done_nxt;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  b3, b2, b1, b0;
    logic [127:0] bwd_key;

    assign {w0, w1, w2, w3} = key_q;

    // Undo one forward round: recover the last three words by XOR, then w0
    // needs SubWord of the recovered previous w3.
    assign b3 = w3 ^ w2;
    assign b2 = w2 ^ w1;
    assign b1 = w1 ^ w0;
    assign b0 = w0 ^ sub_rot(b3) ^ rcon(cnt_q);
    assign bwd_key = {b0, b1, b2, b3};

`ifdef AES_FWD_EXPAND_EN
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key;

    assign f0 = w0 ^ sub_rot(w3) ^ rcon(cnt_q);
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            key_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            key_q  <= key_nxt;
            cnt_q  <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    key_nxt = bus.key_in;
`ifdef AES_FWD_EXPAND_EN
                    cnt_nxt   = 4'd1;
                    state_nxt = EXPAND;
`else
                    cnt_nxt   = 4'd10;
                    state_nxt = EMIT;
`endif
                end
            end
`ifdef AES_FWD_EXPAND_EN
            EXPAND: begin
                key_nxt = fwd_key;
                if (cnt_q == 4'd10) begin
                    state_nxt = EMIT;
                end else begin
                    cnt_nxt = cnt_q + 4'd1;
                end
            end
`endif
            EMIT: begin
                if (bus.rk_ack) begin
                    if (cnt_q != 4'd0) begin
                        key_nxt = bwd_key;
                        cnt_nxt = cnt_q - 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate the data outputs so intermediate expansion values never leak.
    assign bus.busy     = (state != IDLE);
    assign bus.rk_valid = (state == EMIT);
    assign bus.rk_out   = (state == EMIT) ? key_q : '0;
    assign bus.rk_round = (state == EMIT) ? cnt_q : '0;
    assign bus.done     = done_q;

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 inverse key schedule for the decryption datapath. It accepts a 128-bit key and emits the round keys in reverse order, round 10 down to round 0, one per accepted handshake. Each backward step undoes one forward key-expansion round using the existing forward key S-box. It sits between key load and the inverse-cipher round logic, which consumes keys in the order it applies them.

## Interface
- No parameters; AES-128 only.
- clk — input — 1 — single clock, all state on rising edge.
- rst — input — 1 — synchronous, active-high reset.
- start — input — 1 — one-cycle request; sampled only in IDLE.
- key_in — input — 128 — key word w0 in [127:96] … w3 in [31:0]; sampled with start.
- rk_ack — input — 1 — consumer accepts rk_out this cycle.
- busy — output — 1 — high in any state other than IDLE.
- rk_valid — output — 1 — rk_out/rk_round hold a valid round key.
- rk_out — output — 128 — current round key, same word packing as key_in.
- rk_round — output — 4 — round index of rk_out, 10 down to 0.
- done — output — 1 — one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, EXPAND (only when AES_FWD_EXPAND_EN is defined), EMIT.
- IDLE:
  - start=1 loads key_in into the key register.
  - With the macro, also clears the round counter to 1 and goes to EXPAND.
  - Without the macro, sets the round counter to 10 and goes to EMIT.
  - start=0 holds IDLE.
- EXPAND, forward round i:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon(i); w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - After i=10, set the counter to 10 and go to EMIT.
- EMIT: rk_valid=1, rk_out = key register, rk_round = counter.
  - rk_ack=0: hold all outputs stable.
  - rk_ack=1 and counter>0: load the previous key, decrement the counter, stay in EMIT.
  - rk_ack=1 and counter=0: go to IDLE and pulse done.
- Backward step from round r to r−1:
  - w3p = w3 ^ w2; w2p = w2 ^ w1; w1p = w1 ^ w0.
  - w0p = w0 ^ SubWord(RotWord(w3p)) ^ rcon(r).
- RotWord: byte rotate left, so [31:24] moves to the LSB byte.
- rcon(r), top byte only, lower 24 bits zero: 01,02,04,08,10,20,40,80,1b,36 for r=1..10; 00 otherwise.
- SubWord: four instances of the forward key S-box, each byte-parallel.
- start while busy is ignored; no queueing.
- rk_ack while rk_valid=0 is ignored.
- Reset, including mid-operation: state IDLE, counter 0, key register 0. All outputs 0: busy, rk_valid, rk_out, rk_round, done.

## Timing
- start sampled at edge N.
- Without the macro: rk_valid high after edge N with round 10, i.e. 1-cycle latency.
- With the macro:
  - EXPAND occupies edges N+1..N+10.
  - rk_valid is high after edge N+10 with round 10, i.e. 10-cycle latency.
- Throughput: one round key per cycle while rk_ack is held high. rk_valid stays high across steps with no bubble.
- The backward step is combinational from the key register and registered on the accepting edge. rk_out changes only on an accepting edge.
- done is high the single cycle after the edge that accepts round 0. busy is low in that same cycle, so a new start is legal there.
- Minimum full sequence with rk_ack tied high: 11 accept cycles after rk_valid first rises.

## Configuration
- AES_FWD_EXPAND_EN
  - Defined: key_in is the cipher key (round 0). The block runs EXPAND first to reach round 10.
  - Undefined: key_in is the round-10 key. EXPAND state and its logic are omitted, and the first rk_out equals key_in.
- Interface and EMIT behaviour are identical in both builds.

## Test plan
- Macro defined, key_in=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ack=1 -> 10 cycles later rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6. Next cycle rk_round=9, rk_out=ac7766f319fadc2128d12941575c006e.
- Same run continued -> rk_round=1 gives a0fafe1788542cb123a339392a6c7605. rk_round=0 gives 2b7e151628aed2a6abf7158809cf4f3c, then a done pulse and busy=0.
- Macro undefined, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 -> rk_valid one cycle after start with that value. Final round-0 key = 2b7e151628aed2a6abf7158809cf4f3c.
- rk_ack held low 5 cycles at rk_round=9 -> rk_out stays ac7766f3…006e. Then a single ack -> rk_round=8.
- start pulsed during EMIT with a different key -> sequence unaffected. start in the done cycle -> new run begins.
- rst asserted at rk_round=5 -> next cycle all outputs 0. A new start runs a full correct sequence.
